// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - MIPS opcode/funct constants, dispatch station enum and decoded uop layout
package decode_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_AND  = 6'h24;

  typedef enum logic [3:0] {
    STN_NONE   = 4'd0,
    STN_INT    = 4'd1,
    STN_MULDIV = 4'd2,
    STN_BRANCH = 4'd3,
    STN_MEM    = 4'd4
  } rs_station_e;

  // operation holds the opcode for I-type and the funct for SPECIAL (R-type) words.
  typedef struct packed {
    logic [5:0]  operation;
    rs_station_e rs_station;
    logic [5:0]  alu_fn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        has_rs1;
    logic        has_rs2;
    logic        has_rd;
    logic [15:0] imm;
    logic        illegal;
  } uop_t;

  localparam int UOP_W = $bits(uop_t);
  // illegal is the last struct member, so it lands on bit 0 of a flattened uop.
  localparam int UOP_ILLEGAL_BIT = 0;

endpackage

// File: rtl/decode_lane.sv
// rtl/decode_lane.sv - combinational decode of one 32-bit MIPS word into a uop
module decode_lane
  import decode_pkg::*;
(
  input  logic [31:0]      instr,
  output logic [UOP_W-1:0] uop
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rdf;
  uop_t       d;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rdf    = instr[15:11];
  assign uop    = d;

  always_comb begin
    d = '0;
    case (opcode)
      OP_ADDIU, OP_ANDI, OP_LW: begin
        d.operation  = opcode;
        d.rs_station = (opcode == OP_LW) ? STN_MEM : STN_INT;
        d.alu_fn     = (opcode == OP_ANDI) ? 6'd2 : 6'd0;
        d.rs1        = rs;
        d.has_rs1    = 1'b1;
        d.rd         = rt;
        d.has_rd     = 1'b1;
        d.imm        = instr[15:0];
      end
      OP_BEQ, OP_SW: begin
        d.operation  = opcode;
        d.rs_station = (opcode == OP_SW) ? STN_MEM : STN_BRANCH;
        d.alu_fn     = (opcode == OP_SW) ? 6'd1 : 6'd3;
        d.rs1        = rs;
        d.has_rs1    = 1'b1;
        d.rs2        = rt;
        d.has_rs2    = 1'b1;
        d.imm        = instr[15:0];
      end
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU, FN_AND: begin
            d.operation  = funct;
            d.rs_station = STN_INT;
            d.alu_fn     = (funct == FN_AND) ? 6'd1 : 6'd0;
            d.rs1        = rs;
            d.has_rs1    = 1'b1;
            d.rs2        = rt;
            d.has_rs2    = 1'b1;
            d.rd         = rdf;
            d.has_rd     = 1'b1;
          end
          FN_DIV: begin
            d.operation  = funct;
            d.rs_station = STN_MULDIV;
            d.rs1        = rs;
            d.has_rs1    = 1'b1;
            d.rs2        = rt;
            d.has_rs2    = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            d.operation  = funct;
            d.rs_station = STN_MULDIV;
            d.alu_fn     = (funct == FN_MFLO) ? 6'd2 : 6'd1;
            d.rd         = rdf;
            d.has_rd     = 1'b1;
          end
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - circular fetch queue with WIDTH in-order decode/dispatch lanes
// Optional DECODE_ILLEGAL_STALL_EN: freeze output after an illegal instruction is accepted.
module decode_queue
  import decode_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic [WIDTH-1:0]         out_valid,
  input  logic [WIDTH-1:0]         out_ready,
  output logic [WIDTH*PC_W-1:0]    out_pc,
  output logic [WIDTH*UOP_W-1:0]   out_uop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   deq;
  logic [WIDTH-1:0] lane_present;
  logic            enq;
  logic            go;

  assign count    = count_q;
  assign in_ready = (count_q < CW'(DEPTH));
  assign enq      = in_valid && in_ready;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [AW-1:0] idx;
    assign idx             = head + AW'(i);
    assign lane_present[i] = (count_q > CW'(i));
    assign out_pc[i*PC_W +: PC_W] = mem_pc[idx];
    decode_lane u_dec (
      .instr (mem_instr[idx]),
      .uop   (out_uop[i*UOP_W +: UOP_W])
    );
  end

`ifdef DECODE_ILLEGAL_STALL_EN
  logic [WIDTH-1:0] lane_illegal;
  logic             stalled;
  logic             stall_set;
  logic             blocked;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ill
    assign lane_illegal[i] = out_uop[i*UOP_W + UOP_ILLEGAL_BIT];
  end

  // An illegal lane is still shown, but nothing younger than it is.
  always_comb begin
    out_valid = '0;
    blocked   = stalled;
    for (int i = 0; i < WIDTH; i++) begin
      out_valid[i] = lane_present[i] && !blocked;
      if (lane_present[i] && lane_illegal[i]) blocked = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         stalled <= 1'b0;
    else if (flush)     stalled <= 1'b0;
    else if (stall_set) stalled <= 1'b1;
  end
`else
  assign out_valid = lane_present;
`endif

  always_comb begin
    deq = '0;
    go  = 1'b1;
`ifdef DECODE_ILLEGAL_STALL_EN
    stall_set = 1'b0;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      if (go && out_valid[i] && out_ready[i]) begin
        deq = deq + CW'(1);
`ifdef DECODE_ILLEGAL_STALL_EN
        if (lane_illegal[i]) stall_set = 1'b1;
`endif
      end else begin
        go = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail <= tail + AW'(1);
      head    <= head + deq[AW-1:0];
      count_q <= count_q + CW'(enq) - deq;
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      mem_instr[tail] <= in_instr;
      mem_pc[tail]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed table and sequence checks for decode_queue
module tb_decode_queue;
  import decode_pkg::*;

  localparam int WIDTH = 2;
  localparam int DEPTH = 8;
  localparam int PC_W  = 32;

  localparam logic [31:0] I_ADDIU = 32'h24220005;
  localparam logic [31:0] I_ANDI  = 32'h308300FF;
  localparam logic [31:0] I_BEQ   = 32'h10A6FFFE;
  localparam logic [31:0] I_LW    = 32'h8D070008;
  localparam logic [31:0] I_ADDU  = 32'h016C6821;
  localparam logic [31:0] I_MFLO  = 32'h0000A012;
  localparam logic [31:0] I_BAD   = 32'hFC000000;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [31:0]            in_instr = '0;
  logic [PC_W-1:0]        in_pc = '0;
  logic [WIDTH-1:0]       out_valid;
  logic [WIDTH-1:0]       out_ready = '0;
  logic [WIDTH*PC_W-1:0]  out_pc;
  logic [WIDTH*UOP_W-1:0] out_uop;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_uop(out_uop),
    .count(count)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic uop_t lane(input int i);
    return uop_t'(out_uop[i*UOP_W +: UOP_W]);
  endfunction

  function automatic logic [PC_W-1:0] lane_pc(input int i);
    return out_pc[i*PC_W +: PC_W];
  endfunction

  function automatic uop_t mk(input logic [5:0] op, input rs_station_e stn, input logic [5:0] alu,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                              input logic h1, input logic h2, input logic hd,
                              input logic [15:0] imm, input logic ill);
    uop_t u;
    u.operation = op;  u.rs_station = stn; u.alu_fn = alu;
    u.rs1 = r1; u.rs2 = r2; u.rd = rd;
    u.has_rs1 = h1; u.has_rs2 = h2; u.has_rd = hd;
    u.imm = imm; u.illegal = ill;
    return u;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    uop_t        exp;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] exp_q [$];
  logic [31:0] next_pc;
  logic        will_push;
  logic        lgo;
  int          pushes;
  uop_t        u;

  initial begin
    vecs[0]  = '{I_ADDIU,      mk(6'h09, STN_INT,    6'd0, 5'd1,  5'd0,  5'd2,  1, 0, 1, 16'h0005, 0)};
    vecs[1]  = '{I_ANDI,       mk(6'h0C, STN_INT,    6'd2, 5'd4,  5'd0,  5'd3,  1, 0, 1, 16'h00FF, 0)};
    vecs[2]  = '{I_BEQ,        mk(6'h04, STN_BRANCH, 6'd3, 5'd5,  5'd6,  5'd0,  1, 1, 0, 16'hFFFE, 0)};
    vecs[3]  = '{I_LW,         mk(6'h23, STN_MEM,    6'd0, 5'd8,  5'd0,  5'd7,  1, 0, 1, 16'h0008, 0)};
    vecs[4]  = '{32'hAD490010, mk(6'h2B, STN_MEM,    6'd1, 5'd10, 5'd9,  5'd0,  1, 1, 0, 16'h0010, 0)};
    vecs[5]  = '{I_ADDU,       mk(6'h21, STN_INT,    6'd0, 5'd11, 5'd12, 5'd13, 1, 1, 1, 16'h0000, 0)};
    vecs[6]  = '{32'h01CF8024, mk(6'h24, STN_INT,    6'd1, 5'd14, 5'd15, 5'd16, 1, 1, 1, 16'h0000, 0)};
    vecs[7]  = '{32'h0232001A, mk(6'h1A, STN_MULDIV, 6'd0, 5'd17, 5'd18, 5'd0,  1, 1, 0, 16'h0000, 0)};
    vecs[8]  = '{32'h00009810, mk(6'h10, STN_MULDIV, 6'd1, 5'd0,  5'd0,  5'd19, 0, 0, 1, 16'h0000, 0)};
    vecs[9]  = '{I_MFLO,       mk(6'h12, STN_MULDIV, 6'd2, 5'd0,  5'd0,  5'd20, 0, 0, 1, 16'h0000, 0)};
    vecs[10] = '{I_BAD,        mk(6'h00, STN_NONE,   6'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 16'h0000, 1)};
    vecs[11] = '{32'h00221820, mk(6'h00, STN_NONE,   6'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 16'h0000, 1)};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // decode table: each word alone in the queue, seen on lane 0 one cycle after enqueue
    for (int k = 0; k < 12; k++) begin
      do_flush();
      push(vecs[k].instr, 32'h1000 + 32'(4*k));
      check($sformatf("vec%0d_valid", k), 64'(out_valid), 64'b01);
      check($sformatf("vec%0d_uop", k), 64'(lane(0)), 64'(vecs[k].exp));
      check($sformatf("vec%0d_pc", k), 64'(lane_pc(0)), 64'(32'h1000 + 32'(4*k)));
      check($sformatf("vec%0d_count", k), 64'(count), 64'd1);
    end

    // fill to DEPTH, ninth word refused, slot frees the cycle after a dequeue
    do_flush();
    for (int k = 0; k < 8; k++) push(I_ADDU, 32'h4000 + 32'(4*k));
    check("full_count", 64'(count), 64'd8);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_instr = I_MFLO; in_pc = 32'h4FFF0;
    step();
    check("ninth_count", 64'(count), 64'd8);
    check("ninth_in_ready", 64'(in_ready), 64'd0);
    out_ready = 2'b01;
    step();
    in_valid = 1'b0; out_ready = 2'b00;
    check("deq_count", 64'(count), 64'd7);
    check("deq_in_ready", 64'(in_ready), 64'd1);
    check("deq_head_pc", 64'(lane_pc(0)), 64'h4004);

    // in-order acceptance: ready on lane1 alone is ignored
    do_flush();
    push(I_ADDU, 32'h5000);
    push(I_LW, 32'h5004);
    check("pair_valid", 64'(out_valid), 64'b11);
    u = lane(1);
    check("pair_lane1_stn", 64'(u.rs_station), 64'(STN_MEM));
    check("pair_lane1_pc", 64'(lane_pc(1)), 64'h5004);
    out_ready = 2'b10;
    step();
    check("ooo_count", 64'(count), 64'd2);
    check("ooo_head_pc", 64'(lane_pc(0)), 64'h5000);
    out_ready = 2'b11;
    step();
    out_ready = 2'b00;
    check("pair_deq_count", 64'(count), 64'd0);

    // wrap: 20 pushes with mixed dequeue patterns, PCs leave in order
    do_flush();
    next_pc = 32'h6000;
    pushes  = 0;
    exp_q.delete();
    for (int k = 0; k < 40; k++) begin
      in_valid = (k < 20);
      in_instr = I_ADDU;
      in_pc    = next_pc;
      case (k % 4)
        0: out_ready = 2'b00;
        1: out_ready = 2'b01;
        2: out_ready = 2'b11;
        default: out_ready = 2'b10;
      endcase
      if (k >= 20) out_ready = 2'b11;
      #1;
      will_push = in_valid && in_ready;
      lgo = 1'b1;
      for (int j = 0; j < WIDTH; j++) begin
        if (lgo && out_valid[j] && out_ready[j]) begin
          if (exp_q.size() == 0) check($sformatf("wrap_extra_pop_k%0d", k), 64'(lane_pc(j)), 64'hFFFFFFFF_FFFFFFFF);
          else check($sformatf("wrap_pc_k%0d_l%0d", k, j), 64'(lane_pc(j)), 64'(exp_q.pop_front()));
        end else begin
          lgo = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      if (will_push) begin
        exp_q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
        pushes++;
      end
    end
    in_valid = 1'b0; out_ready = 2'b00;
    check("wrap_pushes", 64'(pushes), 64'd20);
    check("wrap_leftover", 64'(exp_q.size()), 64'd0);
    check("wrap_count", 64'(count), 64'd0);

    // flush beats a same-cycle enqueue
    do_flush();
    for (int k = 0; k < 5; k++) push(I_ANDI, 32'h7000 + 32'(4*k));
    check("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1; in_valid = 1'b1; in_instr = I_BEQ; in_pc = 32'hDEAD0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    push(I_ADDIU, 32'h7100);
    check("post_flush_count", 64'(count), 64'd1);
    check("post_flush_pc", 64'(lane_pc(0)), 64'h7100);
    check("post_flush_uop", 64'(lane(0)), 64'(vecs[0].exp));

    // illegal instruction handling
    do_flush();
    push(I_BAD, 32'h9000);
    push(I_ANDI, 32'h9004);
    u = lane(0);
    check("ill_lane0_flag", 64'(u.illegal), 64'd1);
    check("ill_lane0_stn", 64'(u.rs_station), 64'(STN_NONE));
`ifdef DECODE_ILLEGAL_STALL_EN
    check("ill_valid", 64'(out_valid), 64'b01);
    out_ready = 2'b01;
    step();
    check("stall_valid", 64'(out_valid), 64'd0);
    check("stall_count", 64'(count), 64'd1);
    out_ready = 2'b11;
    step();
    step();
    check("stall_hold_valid", 64'(out_valid), 64'd0);
    check("stall_hold_count", 64'(count), 64'd1);
    push(I_ANDI, 32'h9008);
    check("stall_enq_count", 64'(count), 64'd2);
    check("stall_enq_valid", 64'(out_valid), 64'd0);
    out_ready = 2'b00;
    do_flush();
    check("stall_flush_count", 64'(count), 64'd0);
    push(I_ANDI, 32'h900C);
    check("stall_release_valid", 64'(out_valid), 64'b01);
    check("stall_release_pc", 64'(lane_pc(0)), 64'h900C);
`else
    check("ill_valid", 64'(out_valid), 64'b11);
    out_ready = 2'b11;
    step();
    out_ready = 2'b00;
    check("ill_flow_count", 64'(count), 64'd0);
    check("ill_flow_valid", 64'(out_valid), 64'd0);
`endif

    // asynchronous reset mid-cycle
    do_flush();
    push(I_ANDI, 32'hA000);
    push(I_ANDI, 32'hA004);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    #3 rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
